// File: rtl/writeback_logic_gen.sv
// writeback_logic_gen
// Write-side address generator: takes result rows from the compute array over a
// valid/ready handshake and writes them into the shared BRAM as whole tiles of
// ROWS_PER_TILE words. The write address is the latched buffer base (plus an
// optional double-buffer offset), the shared tile pointer and the row counter.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_write         pulse, begins one tile write (only honoured in IDLE)
//   reset_addr_counter  pulse, clears the tile pointer in any state
//   Buffer_Select       000=Q, 001=K, 010=V, 011=OUT, others invalid
//   Double_buffering    adds DB_OFFSET to the selected base
//   in_valid/in_data    result row from the compute array
//   in_ready            row accepted this cycle (high while WRITING)
//   bram_addr/wdata/we  registered BRAM write port
//   write_done          one-cycle pulse, tile complete
//   busy                high while WRITING
//   ptr_wrap            one-cycle pulse with write_done when the tile pointer wraps
//   sel_err             one-cycle pulse after a start with an invalid select
//
// state   | meaning
// IDLE    | waiting for start_write
// WRITING | accepting rows, one BRAM write per handshake
// DONE    | one cycle: tile complete, advance tile pointer

module writeback_logic_gen #(
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 256,
    parameter int BUF_WORDS     = 12288,
    parameter int ROWS_PER_TILE = 32,
    parameter int OUT_BASE      = 36864,
    parameter int DB_OFFSET     = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_write,
    input  logic                  reset_addr_counter,
    input  logic [2:0]            Buffer_Select,
    input  logic                  Double_buffering,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_wdata,
    output logic                  bram_we,
    output logic                  write_done,
    output logic                  busy,
    output logic                  ptr_wrap,
    output logic                  sel_err
);

    localparam int TILES = BUF_WORDS / ROWS_PER_TILE;
    localparam int PTR_W = (TILES > 1) ? $clog2(TILES) : 1;
    localparam int ROW_W = (ROWS_PER_TILE > 1) ? $clog2(ROWS_PER_TILE) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(TILES - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS_PER_TILE - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITING = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] sel_base;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [PTR_W-1:0]      tile_ptr;
    logic [ROW_W-1:0]      row_cnt;
    logic                  sel_ok;
    logic                  accept;
    logic                  last_row;
    logic                  start_ok;

    always_comb begin
        sel_ok   = 1'b1;
        sel_base = '0;
        case (Buffer_Select)
            3'b000:  sel_base = '0;
            3'b001:  sel_base = ADDR_WIDTH'(BUF_WORDS);
            3'b010:  sel_base = ADDR_WIDTH'(2 * BUF_WORDS);
            3'b011:  sel_base = ADDR_WIDTH'(OUT_BASE);
            default: sel_ok   = 1'b0;
        endcase
    end

    assign start_ok = (state == IDLE) && start_write && sel_ok;
    assign accept   = in_valid && in_ready;
    assign last_row = (row_cnt == ROW_LAST);
    // Sum wraps naturally at ADDR_WIDTH bits.
    assign wr_addr  = base_q + ADDR_WIDTH'(32'(tile_ptr) * ROWS_PER_TILE) + ADDR_WIDTH'(row_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start_write && sel_ok) state_nxt = WRITING;
            end
            WRITING: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && last_row) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            bram_wdata <= '0;
            write_done <= 1'b0;
            ptr_wrap   <= 1'b0;
            sel_err    <= 1'b0;
            base_q     <= '0;
            row_cnt    <= '0;
            tile_ptr   <= '0;
        end else begin
            bram_we    <= accept;
            // write_done lands in DONE, alongside the last row's bram_we.
            write_done <= accept && last_row;
            // Wrap is announced with write_done; the pointer itself moves in DONE.
            ptr_wrap   <= accept && last_row && (tile_ptr == PTR_LAST) && !reset_addr_counter;
            sel_err    <= (state == IDLE) && start_write && !sel_ok;

            if (accept) begin
                bram_wdata <= in_data;
                bram_addr  <= wr_addr;
            end

            if (start_ok)
                base_q <= sel_base + (Double_buffering ? ADDR_WIDTH'(DB_OFFSET) : '0);

            if (state == DONE)
                row_cnt <= '0;
            else if (accept)
                row_cnt <= last_row ? '0 : row_cnt + 1'b1;

            // A clear request always beats the end-of-tile increment.
            if (reset_addr_counter)
                tile_ptr <= '0;
            else if (state == DONE)
                tile_ptr <= (tile_ptr == PTR_LAST) ? '0 : tile_ptr + 1'b1;
        end
    end

endmodule

// File: tb/tb_writeback_logic_gen.sv
module tb_writeback_logic_gen;

    localparam int AW    = 16;
    localparam int DW    = 256;
    localparam int BW    = 12288;
    localparam int RPT   = 32;
    localparam int TILES = BW / RPT;

    logic          clk;
    logic          rst_n;
    logic          start_write;
    logic          reset_addr_counter;
    logic [2:0]    Buffer_Select;
    logic          Double_buffering;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wdata;
    logic          bram_we;
    logic          write_done;
    logic          busy;
    logic          ptr_wrap;
    logic          sel_err;

    writeback_logic_gen dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start_write        (start_write),
        .reset_addr_counter (reset_addr_counter),
        .Buffer_Select      (Buffer_Select),
        .Double_buffering   (Double_buffering),
        .in_valid           (in_valid),
        .in_data            (in_data),
        .in_ready           (in_ready),
        .bram_addr          (bram_addr),
        .bram_wdata         (bram_wdata),
        .bram_we            (bram_we),
        .write_done         (write_done),
        .busy               (busy),
        .ptr_wrap           (ptr_wrap),
        .sel_err            (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;
    int n_pushed = 0;
    int ptr_m    = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        time           t;
    } wr_t;

    wr_t exp_q[$];

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int buf_base(input logic [2:0] sel, input bit db);
        int b;
        case (sel)
            3'd0:    b = 0;
            3'd1:    b = BW;
            3'd2:    b = 2 * BW;
            default: b = 3 * BW;
        endcase
        return (b + (db ? 4096 : 0)) % 65536;
    endfunction

    function automatic logic [DW-1:0] rnd_row();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Every BRAM write must match the next expected row exactly one cycle after its handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bram_we) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    check_val("unexpected_we", DW'(exp_q.size()), DW'(1));
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check_val("wr_addr", DW'(bram_addr), DW'(e.addr));
                    check_val("wr_data", bram_wdata, e.data);
                    check_val("wr_latency", DW'($time - e.t), DW'(10));
                end
            end else if (exp_q.size() > 0 && exp_q[0].t + 10 <= $time) begin
                check_val("missing_we", DW'(bram_we), DW'(1));
                void'(exp_q.pop_front());
            end
        end
    end

    // gap_mode: 0 back-to-back, 1 every other cycle, 2 random gaps.
    // rac_row >= 0: clear tile pointer in an idle cycle after that many rows.
    // abort_row >= 0: assert rst_n after that many rows and abandon the tile.
    task automatic run_tile(input logic [2:0] sel, input bit db, input int gap_mode,
                            input bit rac_done, input int rac_row, input int abort_row);
        int  base;
        int  rows;
        int  cyc;
        bit  gap;
        bit  rac_pending;
        logic [AW-1:0] a;
        base        = buf_base(sel, db);
        rows        = 0;
        cyc         = 0;
        rac_pending = (rac_row >= 0);

        @(negedge clk);
        start_write        = 1'b1;
        Buffer_Select      = sel;
        Double_buffering   = db;
        reset_addr_counter = 1'b0;
        in_valid           = 1'($urandom_range(0, 1));
        in_data            = rnd_row();

        while (rows < RPT) begin
            @(negedge clk);
            check_val("ready_busy_done", DW'({in_ready, busy, write_done}), DW'(3'b110));
            cyc++;
            reset_addr_counter = 1'b0;
            if (abort_row >= 0 && rows == abort_row) begin
                start_write = 1'b0;
                in_valid    = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                check_val("abort_flags", DW'({bram_we, write_done, busy, in_ready, ptr_wrap, sel_err}), DW'(0));
                check_val("abort_addr", DW'(bram_addr), DW'(0));
                check_val("abort_data", bram_wdata, DW'(0));
                ptr_m = 0;
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check_val("abort_no_done", DW'({write_done, busy}), DW'(0));
                return;
            end
            // Anything presented at start/select while writing must be ignored.
            start_write      = ($urandom_range(0, 3) == 0);
            Buffer_Select    = 3'($urandom);
            Double_buffering = 1'($urandom);
            if (rac_pending && rows == rac_row) begin
                in_valid           = 1'b0;
                reset_addr_counter = 1'b1;
                rac_pending        = 1'b0;
                ptr_m              = 0;
            end else begin
                case (gap_mode)
                    1:       gap = (cyc % 2 == 0);
                    2:       gap = ($urandom_range(0, 3) == 0);
                    default: gap = 1'b0;
                endcase
                if (cyc > 200) gap = 1'b0;
                in_valid = !gap;
                in_data  = rnd_row();
                if (!gap) begin
                    a = AW'(base + ptr_m * RPT + rows);
                    exp_q.push_back('{addr: a, data: in_data, t: $time});
                    n_pushed++;
                    rows++;
                end
            end
        end

        @(negedge clk);
        check_val("done_flags", DW'({in_ready, busy, write_done, ptr_wrap}),
                  DW'({2'b00, 1'b1, (ptr_m == TILES - 1)}));
        start_write        = 1'($urandom_range(0, 1));
        Buffer_Select      = 3'b000;
        in_valid           = 1'($urandom_range(0, 1));
        in_data            = rnd_row();
        reset_addr_counter = rac_done;
        ptr_m              = rac_done ? 0 : (ptr_m + 1) % TILES;

        @(negedge clk);
        check_val("post_done", DW'({in_ready, busy, write_done, ptr_wrap}), DW'(0));
        start_write        = 1'b0;
        reset_addr_counter = 1'b0;
        in_valid           = 1'($urandom_range(0, 1));
    endtask

    task automatic bad_sel(input logic [2:0] sel);
        @(negedge clk);
        start_write   = 1'b1;
        Buffer_Select = sel;
        in_valid      = 1'b1;
        @(negedge clk);
        check_val("sel_err_pulse", DW'({sel_err, busy, in_ready}), DW'(3'b100));
        start_write = 1'b0;
        in_valid    = 1'b0;
        @(negedge clk);
        check_val("sel_err_clear", DW'({sel_err, busy}), DW'(0));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got %0t expected below 900000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n              = 1'b0;
        start_write        = 1'b0;
        reset_addr_counter = 1'b0;
        Buffer_Select      = 3'b000;
        Double_buffering   = 1'b0;
        in_valid           = 1'b0;
        in_data            = '0;

        #12;
        check_val("reset_flags", DW'({bram_we, write_done, busy, in_ready, ptr_wrap, sel_err}), DW'(0));
        check_val("reset_addr", DW'(bram_addr), DW'(0));
        check_val("reset_data", bram_wdata, DW'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_tile(3'b001, 1'b0, 0, 1'b0, -1, -1);
        run_tile(3'b000, 1'b0, 2, 1'b0, -1, -1);
        run_tile(3'b011, 1'b1, 1, 1'b0, -1, -1);
        run_tile(3'b010, 1'b0, 2, 1'b1, -1, -1);
        run_tile(3'b001, 1'b0, 0, 1'b0, -1, -1);

        bad_sel(3'b111);
        bad_sel(3'($urandom_range(4, 6)));

        run_tile(3'b011, 1'b0, 2, 1'b0, 16, -1);
        run_tile(3'b000, 1'b0, 0, 1'b0, -1, 10);
        run_tile(3'b010, 1'b1, 0, 1'b0, -1, -1);

        @(negedge clk);
        reset_addr_counter = 1'b1;
        ptr_m = 0;
        @(negedge clk);
        reset_addr_counter = 1'b0;
        for (int i = 0; i < TILES; i++)
            run_tile(3'b000, 1'b0, (i % 8 == 0) ? 2 : 0, 1'b0, -1, -1);
        run_tile(3'b000, 1'b0, 0, 1'b0, -1, -1);

        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_val("queue_drained", DW'(exp_q.size()), DW'(0));
        check_val("write_count", DW'(n_writes), DW'(n_pushed));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
